// File: rtl/pipe_hazard_ctrl_8085.sv
// Pipeline hazard controller for an 8085-style pipeline: register/flag scoreboard
// for data hazards plus a small FSM that stalls decode around jumps.
module pipe_hazard_ctrl_8085 #(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned JUMP_PENALTY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [7:0] id_src_mask,
  input  logic [2:0] id_dst,
  input  logic       id_dst_en,
  input  logic       id_wr_flags,
  input  logic       id_is_jump,
  input  logic       id_is_cond,
  input  logic       ex_br_resolved,
  input  logic       ex_br_taken,
  input  logic       wb_valid,
  input  logic [2:0] wb_dst,
  input  logic       wb_dst_en,
  input  logic       wb_flags,
  output logic       stall,
  output logic       stall_jump,
  output logic       flush,
  output logic       sb_err,
  output logic [7:0] jump_stall_cnt
);

  typedef enum logic [1:0] {RUN, PENALTY, RESOLVE} jstate_e;

  jstate_e          state_q, state_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic             flush_q, flush_d;
  logic [7:0]       jcnt_q, jcnt_d;
  logic [7:0][1:0]  pend_q, pend_d;
  logic             err_q, err_d;
  logic [7:0]       busy, inc, dec;
  logic             raw_stall, sat_stall, issue;

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < 8; i++) busy[i] = |pend_q[i];
  end

  // Hazard checks look only at registered pending counts, so a retiring
  // writeback releases its consumer one cycle later.
  assign raw_stall  = id_valid & |(id_src_mask & busy);
  assign sat_stall  = id_valid & ((id_dst_en & (pend_q[id_dst] == 2'(MAX_INFLIGHT))) |
                                  (id_wr_flags & (pend_q[7] == 2'(MAX_INFLIGHT))));
  assign stall_jump = (state_q != RUN);
  assign stall      = raw_stall | sat_stall | stall_jump;
  assign issue      = id_valid & ~stall;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      inc[i] = (issue & id_dst_en & (id_dst == i[2:0])) | (issue & id_wr_flags & (i == 7));
      dec[i] = (wb_valid & wb_dst_en & (wb_dst == i[2:0])) | (wb_valid & wb_flags & (i == 7));
    end
  end

  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (inc[i] & ~dec[i]) begin
        pend_d[i] = pend_q[i] + 2'd1;
      end else if (dec[i] & ~inc[i]) begin
        if (pend_q[i] == 2'd0) err_d = 1'b1;
        else                   pend_d[i] = pend_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    flush_d = 1'b0;
    jcnt_d  = stall_jump ? jcnt_q + 8'd1 : jcnt_q;
    case (state_q)
      RUN: begin
        if (issue & id_is_jump) begin
          if (id_is_cond) begin
            state_d = RESOLVE;
          end else begin
            state_d = PENALTY;
            pcnt_d  = 3'(JUMP_PENALTY);
          end
        end
      end
      PENALTY: begin
        pcnt_d = pcnt_q - 3'd1;
        if (pcnt_q <= 3'd1) begin
          state_d = RUN;
          pcnt_d  = '0;
        end
      end
      RESOLVE: begin
        if (ex_br_resolved) begin
          state_d = RUN;
          flush_d = ex_br_taken;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pcnt_q  <= '0;
      flush_q <= 1'b0;
      jcnt_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      flush_q <= flush_d;
      jcnt_q  <= jcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign flush          = flush_q;
  assign sb_err         = err_q;
  assign jump_stall_cnt = jcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl_8085.sv
// Scoreboard bench for pipe_hazard_ctrl_8085: a driver predicts each cycle's outputs
// from a reference model into a queue; a monitor pops and compares.
module tb_pipe_hazard_ctrl_8085;
  localparam int MAXI = 3;
  localparam int JP   = 2;

  logic clk = 1'b0;
  logic rst, id_valid, id_dst_en, id_wr_flags, id_is_jump, id_is_cond;
  logic ex_br_resolved, ex_br_taken, wb_valid, wb_dst_en, wb_flags;
  logic [7:0] id_src_mask;
  logic [2:0] id_dst, wb_dst;
  logic stall, stall_jump, flush, sb_err;
  logic [7:0] jump_stall_cnt;

  pipe_hazard_ctrl_8085 #(.MAX_INFLIGHT(MAXI), .JUMP_PENALTY(JP)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_mask(id_src_mask),
    .id_dst(id_dst), .id_dst_en(id_dst_en), .id_wr_flags(id_wr_flags),
    .id_is_jump(id_is_jump), .id_is_cond(id_is_cond),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_dst_en(wb_dst_en), .wb_flags(wb_flags),
    .stall(stall), .stall_jump(stall_jump), .flush(flush), .sb_err(sb_err),
    .jump_stall_cnt(jump_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    logic       st;
    logic       sj;
    logic       fl;
    logic       er;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  event ev_sample;
  int   nchecks = 0;
  int   nerrors = 0;

  // reference model: outstanding writes per register, sticky error, jump bookkeeping
  int pend[8];
  bit merr;
  int pen_left;
  bit resolving;
  bit flush_nx;
  int mcnt;

  task automatic chk(input string nm, input int ph, input int act, input int exp_v);
    nchecks++;
    if (act != exp_v) begin
      nerrors++;
      $display("FAIL %s phase %0d: got %0d expected %0d", nm, ph, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_sample);
      if (q.size() == 0) begin
        chk("queue_underrun", 0, 1, 0);
      end else begin
        e = q.pop_front();
        chk("stall",          e.ph, int'(stall),          int'(e.st));
        chk("stall_jump",     e.ph, int'(stall_jump),     int'(e.sj));
        chk("flush",          e.ph, int'(flush),          int'(e.fl));
        chk("sb_err",         e.ph, int'(sb_err),         int'(e.er));
        chk("jump_stall_cnt", e.ph, int'(jump_stall_cnt), int'(e.cnt));
      end
    end
  end

  task automatic idle();
    rst = 0; id_valid = 0; id_src_mask = '0; id_dst = '0; id_dst_en = 0;
    id_wr_flags = 0; id_is_jump = 0; id_is_cond = 0; ex_br_resolved = 0;
    ex_br_taken = 0; wb_valid = 0; wb_dst = '0; wb_dst_en = 0; wb_flags = 0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick(input int ph);
    exp_t e;
    bit [7:0] busy;
    bit raw, sat, sj, stl, iss;
    int inc[8];
    int dec[8];
    #1;
    if (rst) begin
      foreach (pend[i]) pend[i] = 0;
      merr = 0; pen_left = 0; resolving = 0; flush_nx = 0; mcnt = 0;
    end
    for (int i = 0; i < 8; i++) busy[i] = (pend[i] != 0);
    raw = id_valid && ((id_src_mask & busy) != 0);
    sat = id_valid && ((id_dst_en && pend[id_dst] == MAXI) || (id_wr_flags && pend[7] == MAXI));
    sj  = (pen_left > 0) || resolving;
    stl = raw || sat || sj;
    e.ph = ph; e.st = stl; e.sj = sj; e.fl = flush_nx; e.er = merr; e.cnt = 8'(mcnt);
    q.push_back(e);
    -> ev_sample;
    if (!rst) begin
      iss = id_valid && !stl;
      foreach (inc[i]) begin inc[i] = 0; dec[i] = 0; end
      if (iss && id_dst_en)      inc[id_dst]++;
      if (iss && id_wr_flags)    inc[7]++;
      if (wb_valid && wb_dst_en) dec[wb_dst]++;
      if (wb_valid && wb_flags)  dec[7]++;
      for (int i = 0; i < 8; i++) begin
        if (dec[i] > inc[i] && pend[i] == 0) merr = 1;
        else pend[i] = pend[i] + inc[i] - dec[i];
      end
      flush_nx = 0;
      if (sj) mcnt = (mcnt + 1) % 256;
      if (pen_left > 0) pen_left--;
      else if (resolving) begin
        if (ex_br_resolved) begin resolving = 0; flush_nx = ex_br_taken; end
      end else if (iss && id_is_jump) begin
        if (id_is_cond) resolving = 1;
        else pen_left = JP;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    idle();
    rst = 1;
    @(negedge clk);
    tick(1); tick(1);
    // data hazard on A
    idle(); id_valid = 1; id_dst = 3'd6; id_dst_en = 1; tick(2);
    idle(); id_valid = 1; id_src_mask = 8'h40; tick(2); tick(2); tick(2);
    wb_valid = 1; wb_dst = 3'd6; wb_dst_en = 1; tick(2);
    idle(); id_valid = 1; id_src_mask = 8'h40; tick(2);
    // saturation on B
    for (int i = 0; i < 3; i++) begin
      idle(); id_valid = 1; id_dst = 3'd0; id_dst_en = 1; tick(3);
    end
    tick(3); tick(3);
    wb_valid = 1; wb_dst = 3'd0; wb_dst_en = 1; tick(3);
    idle(); id_valid = 1; id_dst = 3'd0; id_dst_en = 1; tick(3);
    for (int i = 0; i < 3; i++) begin
      idle(); wb_valid = 1; wb_dst = 3'd0; wb_dst_en = 1; tick(3);
    end
    // unconditional jump
    idle(); id_valid = 1; id_is_jump = 1; tick(4);
    idle(); for (int i = 0; i < 4; i++) tick(4);
    // conditional jump taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      idle(); id_valid = 1; id_is_jump = 1; id_is_cond = 1; tick(5);
      idle(); tick(5); tick(5);
      ex_br_resolved = 1; ex_br_taken = 1'(t); tick(5);
      idle(); tick(5); tick(5);
    end
    // conditional jump waiting on busy flags
    idle(); id_valid = 1; id_wr_flags = 1; tick(6);
    idle(); id_valid = 1; id_is_jump = 1; id_is_cond = 1; id_src_mask = 8'h80;
    tick(6); tick(6);
    ex_br_resolved = 1; ex_br_taken = 1; wb_valid = 1; wb_flags = 1; tick(6);
    ex_br_resolved = 0; ex_br_taken = 0; wb_valid = 0; wb_flags = 0; tick(6);
    idle(); tick(6); ex_br_resolved = 1; tick(6); idle(); tick(6);
    // underflow on C
    idle(); wb_valid = 1; wb_dst = 3'd1; wb_dst_en = 1; tick(7);
    idle(); tick(7);
    id_valid = 1; id_src_mask = 8'h02; tick(7);
    // reset mid-resolve
    idle(); id_valid = 1; id_dst = 3'd3; id_dst_en = 1; tick(8);
    idle(); id_valid = 1; id_is_jump = 1; id_is_cond = 1; tick(8);
    idle(); tick(8);
    rst = 1; tick(8);
    idle(); id_valid = 1; id_src_mask = 8'hFF; tick(8);
    // random traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      rst            = ($urandom_range(0, 99) == 0);
      id_valid       = 1'($urandom_range(0, 1));
      id_src_mask    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      id_dst         = 3'($urandom_range(0, 6));
      id_dst_en      = 1'($urandom_range(0, 1));
      id_wr_flags    = ($urandom_range(0, 3) == 0);
      id_is_jump     = ($urandom_range(0, 7) == 0);
      id_is_cond     = 1'($urandom_range(0, 1));
      ex_br_resolved = ($urandom_range(0, 2) == 0);
      ex_br_taken    = 1'($urandom_range(0, 1));
      wb_valid       = 1'($urandom_range(0, 1));
      wb_dst         = 3'($urandom_range(0, 6));
      wb_dst_en      = 1'($urandom_range(0, 1));
      wb_flags       = 1'($urandom_range(0, 1));
      if (wb_valid && pend[wb_dst] == 0) wb_dst_en = 0;
      if (wb_valid && pend[7] == 0)      wb_flags = 0;
      tick(9);
    end
    idle();
    @(negedge clk); #2;
    chk("queue_drain", 10, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
